// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell is time-shared across the operand
// bits, LSB first, with the carry held in a flip-flop between bits.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c0_i,
  output logic s_o,
  output logic c_o
);
  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c0_i;
  assign c_o = (a_i & b_i) | (c0_i & p);
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  // state | meaning
  // IDLE  | waiting for start; sum/cout hold last result
  // RUN   | one bit pair per edge through the shared full adder
  // DONE  | result published, done pulse for one cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int          CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  pr_q, pr_d;
  logic          cr_q, cr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic fa_s, fa_c;

  full_adder u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .c0_i (cr_q),
    .s_o  (fa_s),
    .c_o  (fa_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    pr_d    = pr_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          cr_d    = cin_i;
          cnt_d   = '0;
          pr_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        pr_d  = {fa_s, pr_q[N-1:1]};
        cr_d  = fa_c;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the shifted value directly so sum includes this bit.
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, pr_q[N-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      pr_q    <= '0;
      cr_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pr_q    <= pr_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
endmodule
